// File: rtl/ysyx_23060136_branch_pkg.sv
// Shared types and constants for EXU2 branch resolution.
package ysyx_23060136_branch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHADOW = 2'd1,
    HELD   = 2'd2
  } br_state_t;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [63:0] JALR_MASK = ~64'd1;

endpackage

// File: rtl/ysyx_23060136_branch_cmp.sv
// Combinational B-type condition evaluator: eq/neq, and signed or unsigned ge/lt.
module ysyx_23060136_branch_cmp #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_unsigned,
  input  logic            cmp_eq,
  input  logic            cmp_neq,
  input  logic            cmp_ge,
  input  logic            cmp_lt,
  output logic            taken
);

  logic eq;
  logic lt;

  always_comb begin
    eq    = (rs1 == rs2);
    lt    = is_unsigned ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
    taken = (cmp_eq & eq) | (cmp_neq & ~eq) | (cmp_ge & ~lt) | (cmp_lt & lt);
  end

endmodule

// File: rtl/ysyx_23060136_exu_branch_resolve.sv
// EXU2 branch/jump resolution: registered PC redirect, front-end flush, wrong-path kill, PHT training.
// Optional perf counters under YSYX_23060136_BRANCH_PERF_EN.
module ysyx_23060136_exu_branch_resolve
  import ysyx_23060136_branch_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned PERF_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FORWARD_stallEX2,
  input  logic              EXU2_commit,
  input  logic [XLEN-1:0]   EXU2_pc,
  input  logic [INST_W-1:0] EXU2_inst,
  input  logic              EXU2_pre_take,
  input  logic [XLEN-1:0]   EXU2_HAZARD_rs1_data,
  input  logic [XLEN-1:0]   EXU2_HAZARD_rs2_data,
  input  logic [XLEN-1:0]   EXU2_HAZARD_csr_rs_data,
  input  logic [XLEN-1:0]   EXU2_imm,
  input  logic              EXU2_jump,
  input  logic              EXU2_Btype,
  input  logic              EXU2_pc_plus_imm,
  input  logic              EXU2_rs1_plus_imm,
  input  logic              EXU2_csr_plus_imm,
  input  logic              EXU2_cmp_eq,
  input  logic              EXU2_cmp_neq,
  input  logic              EXU2_cmp_ge,
  input  logic              EXU2_cmp_lt,
  output logic              BRANCH_redirect_valid,
  output logic [XLEN-1:0]   BRANCH_redirect_pc,
  output logic              BRANCH_flush,
  output logic              BRANCH_kill_EX2,
  output logic              BRANCH_pht_valid,
  output logic [XLEN-1:0]   BRANCH_pht_pc,
  output logic              BRANCH_pht_taken
`ifdef YSYX_23060136_BRANCH_PERF_EN
  ,
  output logic [PERF_W-1:0] BRANCH_perf_branch,
  output logic [PERF_W-1:0] BRANCH_perf_miss
`endif
);

  br_state_t       state_q, state_d;
  logic            taken, eval, is_branch, mispredict, pht_fire;
  logic [XLEN-1:0] target;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            flush_q, flush_d;
  logic            kill_q, kill_d;
  logic            pht_valid_q, pht_valid_d;
  logic [XLEN-1:0] pht_pc_q, pht_pc_d;
  logic            pht_taken_q, pht_taken_d;
  logic            pht_done_q, pht_done_d;

  logic            inst_unused;
  assign inst_unused = ^{EXU2_inst[INST_W-1:14], EXU2_inst[12:0]};

  ysyx_23060136_branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1         (EXU2_HAZARD_rs1_data),
    .rs2         (EXU2_HAZARD_rs2_data),
    .is_unsigned (EXU2_inst[13]),
    .cmp_eq      (EXU2_cmp_eq),
    .cmp_neq     (EXU2_cmp_neq),
    .cmp_ge      (EXU2_cmp_ge),
    .cmp_lt      (EXU2_cmp_lt),
    .taken       (taken)
  );

  always_comb begin
    eval      = EXU2_commit & (state_q == IDLE);
    is_branch = EXU2_Btype | EXU2_jump;

    target = EXU2_pc + XLEN'(PC_STEP);
    if (!(EXU2_Btype & ~taken)) begin
      if (EXU2_pc_plus_imm)       target = EXU2_pc + EXU2_imm;
      else if (EXU2_rs1_plus_imm) target = (EXU2_HAZARD_rs1_data + EXU2_imm) & JALR_MASK[XLEN-1:0];
      else if (EXU2_csr_plus_imm) target = EXU2_HAZARD_csr_rs_data + EXU2_imm;
    end

    mispredict = eval & ((EXU2_Btype & (taken != EXU2_pre_take))
                       | (EXU2_jump & EXU2_pc_plus_imm & ~EXU2_pre_take)
                       | (EXU2_jump & (EXU2_rs1_plus_imm | EXU2_csr_plus_imm)));

    state_d = state_q;
    case (state_q)
      IDLE:         if (mispredict) state_d = FORWARD_stallEX2 ? HELD : SHADOW;
      SHADOW, HELD: if (!FORWARD_stallEX2) state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    redirect_valid_d = mispredict;
    redirect_pc_d    = mispredict ? target : '0;
    flush_d          = (state_d != IDLE);
    kill_d           = (state_d == SHADOW);

    // A branch held in EXU2 trains the predictor only once per stall episode.
    pht_fire    = eval & is_branch & ~pht_done_q;
    pht_valid_d = pht_fire;
    pht_pc_d    = pht_fire ? EXU2_pc : '0;
    pht_taken_d = pht_fire & (EXU2_Btype ? taken : 1'b1);
    pht_done_d  = FORWARD_stallEX2 & (pht_done_q | (eval & is_branch));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      kill_q           <= 1'b0;
      pht_valid_q      <= 1'b0;
      pht_pc_q         <= '0;
      pht_taken_q      <= 1'b0;
      pht_done_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      kill_q           <= kill_d;
      pht_valid_q      <= pht_valid_d;
      pht_pc_q         <= pht_pc_d;
      pht_taken_q      <= pht_taken_d;
      pht_done_q       <= pht_done_d;
    end
  end

  assign BRANCH_redirect_valid = redirect_valid_q;
  assign BRANCH_redirect_pc    = redirect_pc_q;
  assign BRANCH_flush          = flush_q;
  assign BRANCH_kill_EX2       = kill_q;
  assign BRANCH_pht_valid      = pht_valid_q;
  assign BRANCH_pht_pc         = pht_pc_q;
  assign BRANCH_pht_taken      = pht_taken_q;

`ifdef YSYX_23060136_BRANCH_PERF_EN
  logic [PERF_W-1:0] perf_branch_q, perf_branch_d;
  logic [PERF_W-1:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_branch_d = perf_branch_q;
    perf_miss_d   = perf_miss_q;
    if (pht_valid_d && !(&perf_branch_q))    perf_branch_d = perf_branch_q + 1'b1;
    if (redirect_valid_d && !(&perf_miss_q)) perf_miss_d   = perf_miss_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_q <= '0;
      perf_miss_q   <= '0;
    end else begin
      perf_branch_q <= perf_branch_d;
      perf_miss_q   <= perf_miss_d;
    end
  end

  assign BRANCH_perf_branch = perf_branch_q;
  assign BRANCH_perf_miss   = perf_miss_q;
`else
  localparam int unsigned PERF_W_unused = PERF_W;
`endif

endmodule

// File: tb/tb_ysyx_23060136_exu_branch_resolve.sv
// Self-checking bench for ysyx_23060136_exu_branch_resolve (directed scenarios plus randomized model check).
module tb_ysyx_23060136_exu_branch_resolve;

`ifdef YSYX_23060136_BRANCH_PERF_EN
  localparam int unsigned TB_PW = 3;
`else
  localparam int unsigned TB_PW = 64;
`endif

  localparam int K_NONE = 0, K_BEQ = 1, K_BNE = 2, K_BLT = 3, K_BGE = 4, K_BLTU = 5,
                 K_BGEU = 6, K_JAL = 7, K_JALR = 8, K_CSRJ = 9;

  logic        clk = 1'b0;
  logic        rst, stall, commit, pre_take, jump, btype, ppi, rpi, cpi, ceq, cneq, cge, clt;
  logic [63:0] pc, rs1, rs2, csr, imm;
  logic [31:0] inst;
  logic        rv, flush, kill, pv, ptaken;
  logic [63:0] rpc, ppc;
  logic [4:0]  flg;
  int          total = 0;
  int          bad = 0;
`ifdef YSYX_23060136_BRANCH_PERF_EN
  logic [TB_PW-1:0] perf_branch, perf_miss;
`endif

  assign flg = {rv, flush, kill, pv, ptaken};

  always #5 clk = ~clk;

  ysyx_23060136_exu_branch_resolve #(.XLEN(64), .INST_W(32), .PERF_W(TB_PW)) dut (
    .clk(clk), .rst(rst), .FORWARD_stallEX2(stall), .EXU2_commit(commit),
    .EXU2_pc(pc), .EXU2_inst(inst), .EXU2_pre_take(pre_take),
    .EXU2_HAZARD_rs1_data(rs1), .EXU2_HAZARD_rs2_data(rs2), .EXU2_HAZARD_csr_rs_data(csr),
    .EXU2_imm(imm), .EXU2_jump(jump), .EXU2_Btype(btype),
    .EXU2_pc_plus_imm(ppi), .EXU2_rs1_plus_imm(rpi), .EXU2_csr_plus_imm(cpi),
    .EXU2_cmp_eq(ceq), .EXU2_cmp_neq(cneq), .EXU2_cmp_ge(cge), .EXU2_cmp_lt(clt),
    .BRANCH_redirect_valid(rv), .BRANCH_redirect_pc(rpc), .BRANCH_flush(flush),
    .BRANCH_kill_EX2(kill), .BRANCH_pht_valid(pv), .BRANCH_pht_pc(ppc), .BRANCH_pht_taken(ptaken)
`ifdef YSYX_23060136_BRANCH_PERF_EN
    , .BRANCH_perf_branch(perf_branch), .BRANCH_perf_miss(perf_miss)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [63:0] p, input logic [63:0] im,
                      input logic [63:0] a, input logic [63:0] b, input logic pre, input logic stl);
    logic [2:0] f3;
    commit = 1'b1; pc = p; imm = im; rs1 = a; rs2 = b; csr = ~a; pre_take = pre; stall = stl;
    {jump, btype, ppi, rpi, cpi, ceq, cneq, cge, clt} = '0;
    f3 = 3'd0;
    case (k)
      K_BEQ:  begin btype = 1; ppi = 1; ceq = 1;  f3 = 3'd0; end
      K_BNE:  begin btype = 1; ppi = 1; cneq = 1; f3 = 3'd1; end
      K_BLT:  begin btype = 1; ppi = 1; clt = 1;  f3 = 3'd4; end
      K_BGE:  begin btype = 1; ppi = 1; cge = 1;  f3 = 3'd5; end
      K_BLTU: begin btype = 1; ppi = 1; clt = 1;  f3 = 3'd6; end
      K_BGEU: begin btype = 1; ppi = 1; cge = 1;  f3 = 3'd7; end
      K_JAL:  begin jump = 1; ppi = 1; end
      K_JALR: begin jump = 1; rpi = 1; end
      K_CSRJ: begin jump = 1; cpi = 1; end
      default: ;
    endcase
    inst = 32'h0000_0063 | {17'd0, f3, 12'd0};
  endtask

  task automatic idle();
    commit = 1'b0; stall = 1'b0;
    {jump, btype, ppi, rpi, cpi, ceq, cneq, cge, clt} = '0;
  endtask

  // Architectural outcome of one instruction, straight from the ISA rules.
  task automatic ref_eval(input int k, input logic [63:0] p, input logic [63:0] im,
                          input logic [63:0] a, input logic [63:0] b, input logic pre,
                          output logic tk, output logic [63:0] tgt, output logic mis);
    tk = 1'b0;
    case (k)
      K_BEQ:  tk = (a == b);
      K_BNE:  tk = (a != b);
      K_BLT:  tk = ($signed(a) < $signed(b));
      K_BGE:  tk = !($signed(a) < $signed(b));
      K_BLTU: tk = (a < b);
      K_BGEU: tk = !(a < b);
      default: tk = 1'b1;
    endcase
    tgt = p + 64'd4;
    mis = 1'b0;
    if (k >= K_BEQ && k <= K_BGEU) begin
      tgt = tk ? p + im : p + 64'd4;
      mis = (tk != pre);
    end else if (k == K_JAL) begin
      tgt = p + im; mis = !pre;
    end else if (k == K_JALR) begin
      tgt = (a + im) & 64'hFFFF_FFFF_FFFF_FFFE; mis = 1'b1;
    end else if (k == K_CSRJ) begin
      tgt = ~a + im; mis = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    total++;
    if (flg !== 5'b0 || rpc !== 64'd0 || ppc !== 64'd0) begin
      bad++; $display("FAIL reset flags=%b rpc=%h ppc=%h want 00000/0/0", flg, rpc, ppc);
    end
    rst = 1'b0;
  endtask

  task automatic test_beq();
    load(K_BEQ, 64'h8000_0000, 64'h10, 64'd5, 64'd5, 1'b0, 1'b0);
    tick();
    total++;
    if (flg !== 5'b11111 || rpc !== 64'h8000_0010 || ppc !== 64'h8000_0000) begin
      bad++; $display("FAIL beq_miss flags=%b rpc=%h ppc=%h want 11111/80000010/80000000", flg, rpc, ppc);
    end
    idle(); tick();
    total++;
    if (flg !== 5'b0 || rpc !== 64'd0 || ppc !== 64'd0) begin
      bad++; $display("FAIL beq_after flags=%b rpc=%h want 00000/0", flg, rpc);
    end
    load(K_BEQ, 64'h8000_0000, 64'h10, 64'd5, 64'd5, 1'b1, 1'b0);
    tick();
    total++;
    if (flg !== 5'b00011 || rpc !== 64'd0 || ppc !== 64'h8000_0000) begin
      bad++; $display("FAIL beq_hit flags=%b rpc=%h want 00011/0", flg, rpc);
    end
    idle(); tick();
    total++;
    if (flg !== 5'b0) begin bad++; $display("FAIL beq_hit_pulse flags=%b want 00000", flg); end
  endtask

  task automatic test_unsigned();
    load(K_BLTU, 64'h8000_1000, 64'h20, '1, 64'd1, 1'b1, 1'b0);
    tick();
    total++;
    if (flg !== 5'b11110 || rpc !== 64'h8000_1004) begin
      bad++; $display("FAIL bltu flags=%b rpc=%h want 11110/80001004", flg, rpc);
    end
    idle(); tick();
    load(K_BLT, 64'h8000_1000, 64'h20, '1, 64'd1, 1'b1, 1'b0);
    tick();
    total++;
    if (flg !== 5'b00011 || rpc !== 64'd0) begin
      bad++; $display("FAIL blt_signed flags=%b rpc=%h want 00011/0", flg, rpc);
    end
    idle(); tick();
  endtask

  task automatic test_held_jalr();
    load(K_JALR, 64'h8000_2000, 64'd0, 64'h8000_0103, 64'd0, 1'b1, 1'b1);
    tick();
    total++;
    if (flg !== 5'b11011 || rpc !== 64'h8000_0102) begin
      bad++; $display("FAIL held_first flags=%b rpc=%h want 11011/80000102", flg, rpc);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (flg !== 5'b01000) begin bad++; $display("FAIL held_hold%0d flags=%b want 01000", i, flg); end
    end
    stall = 1'b0;
    tick();
    total++;
    if (flg !== 5'b0) begin bad++; $display("FAIL held_release flags=%b want 00000", flg); end
    idle();
  endtask

  task automatic test_shadow_stall();
    load(K_JAL, 64'h8000_3000, 64'h100, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    total++;
    if (flg !== 5'b11111 || rpc !== 64'h8000_3100) begin
      bad++; $display("FAIL shadow_first flags=%b rpc=%h want 11111/80003100", flg, rpc);
    end
    load(K_BEQ, 64'h8000_3004, 64'h40, 64'd7, 64'd7, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (flg !== 5'b01100) begin bad++; $display("FAIL shadow_hold%0d flags=%b want 01100", i, flg); end
    end
    stall = 1'b0;
    tick();
    total++;
    if (flg !== 5'b0) begin bad++; $display("FAIL shadow_exit flags=%b want 00000", flg); end
    idle(); tick();
  endtask

  task automatic test_pht_once();
    load(K_BNE, 64'h8000_4000, 64'h8, 64'd1, 64'd2, 1'b1, 1'b1);
    tick();
    total++;
    if (flg !== 5'b00011 || ppc !== 64'h8000_4000) begin
      bad++; $display("FAIL pht_first flags=%b ppc=%h want 00011/80004000", flg, ppc);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stall = 1'b0;
      tick();
      total++;
      if (flg !== 5'b0) begin bad++; $display("FAIL pht_once%0d flags=%b want 00000", i, flg); end
    end
    idle(); tick();
  endtask

  task automatic test_reset_abort();
    load(K_JAL, 64'h8000_5000, 64'h200, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    total++;
    if (flg !== 5'b0 || rpc !== 64'd0 || ppc !== 64'd0) begin
      bad++; $display("FAIL rst_abort flags=%b rpc=%h want 00000/0", flg, rpc);
    end
    rst = 1'b0;
    load(K_CSRJ, 64'h8000_6000, 64'h4, 64'hFFFF_FFFF_7FFF_FFFF, 64'd0, 1'b1, 1'b0);
    tick();
    total++;
    if (flg !== 5'b11111 || rpc !== 64'h0000_0000_8000_0004) begin
      bad++; $display("FAIL rst_then_csrj flags=%b rpc=%h want 11111/80000004", flg, rpc);
    end
    idle(); tick();
  endtask

  task automatic test_random();
    int          m_st = 0;
    bit          m_done = 0;
    logic        tk, mis, e_rv, e_pv, e_pt, br, ev, cm, rs, stl, pre;
    logic [63:0] tgt, e_rpc, e_ppc, p, im, a, b;
    logic [4:0]  e_flg;
    int          k;
    for (int i = 0; i < 500; i++) begin
      rs  = ($urandom_range(0, 39) == 0);
      cm  = ($urandom_range(0, 3) != 0);
      k   = $urandom_range(0, 9);
      p   = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h000F_FFFC)};
      im  = {{52{1'b0}}, 12'($urandom)} - 64'h800;
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 2) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = ~b;
      pre = 1'($urandom);
      stl = ($urandom_range(0, 2) == 0);
      load(k, p, im, a, b, pre, stl);
      commit = cm; rst = rs;
      ref_eval(k, p, im, a, b, pre, tk, tgt, mis);
      if (rs) begin
        e_rv = 0; e_rpc = 0; e_pv = 0; e_ppc = 0; e_pt = 0; m_st = 0; m_done = 0;
      end else begin
        ev    = cm && (m_st == 0);
        br    = ev && (k != K_NONE);
        mis   = ev && (k != K_NONE) && mis;
        e_rv  = mis;
        e_rpc = mis ? tgt : 64'd0;
        e_pv  = br && !m_done;
        e_ppc = e_pv ? p : 64'd0;
        e_pt  = e_pv && tk;
        if (m_st == 0) m_st = mis ? (stl ? 2 : 1) : 0;
        else if (!stl) m_st = 0;
        m_done = stl && (m_done || br);
      end
      e_flg = {e_rv, m_st != 0, m_st == 1, e_pv, e_pt};
      tick();
      total++;
      if (flg !== e_flg) begin
        bad++; $display("FAIL rand_flags[%0d] kind=%0d flags=%b want %b", i, k, flg, e_flg);
      end
      total++;
      if (rpc !== e_rpc || ppc !== e_ppc) begin
        bad++; $display("FAIL rand_pc[%0d] rpc=%h ppc=%h want %h/%h", i, rpc, ppc, e_rpc, e_ppc);
      end
    end
    rst = 1'b0; idle(); tick(); tick();
  endtask

`ifdef YSYX_23060136_BRANCH_PERF_EN
  task automatic test_perf();
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    load(K_BEQ, 64'h8000_7000, 64'h10, 64'd3, 64'd3, 1'b1, 1'b0); tick();
    load(K_BEQ, 64'h8000_7010, 64'h10, 64'd3, 64'd4, 1'b1, 1'b0); tick();
    idle(); tick();
    load(K_JAL, 64'h8000_7020, 64'h30, 64'd0, 64'd0, 1'b1, 1'b0); tick();
    idle(); tick();
    total++;
    if (perf_branch !== 3'd3 || perf_miss !== 3'd1) begin
      bad++; $display("FAIL perf_count branch=%0d miss=%0d want 3/1", perf_branch, perf_miss);
    end
    for (int i = 0; i < 8; i++) begin
      load(K_JALR, 64'h8000_8000, 64'h4, 64'h8000_0000, 64'd0, 1'b1, 1'b0); tick();
      idle(); tick();
    end
    total++;
    if (perf_branch !== 3'd7 || perf_miss !== 3'd7) begin
      bad++; $display("FAIL perf_saturate branch=%0d miss=%0d want 7/7", perf_branch, perf_miss);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; idle();
    pc = '0; rs1 = '0; rs2 = '0; csr = '0; imm = '0; inst = '0; pre_take = 1'b0;
    test_reset();
    test_beq();
    test_unsigned();
    test_held_jalr();
    test_shadow_stall();
    test_pht_once();
    test_reset_abort();
    test_random();
`ifdef YSYX_23060136_BRANCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
